grid_arbiter: RTL and testbench
===============================

GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 SHALL have ports `clock` (input, 1) and `reset` (input, 1): one clock; reset is synchronous and active-high.
REQ-002 SHALL have, per requester r in {ld, gl, rd} (level loader, game logic, renderer), `r_req` (input, 1): access request, held high until granted.
REQ-003 SHALL have `r_we` (input, 1): 1 = write, 0 = read; rd_we is ignored and treated as 0.
REQ-004 SHALL have `r_x` (input, 6) and `r_y` (input, 5): grid column and row.
REQ-005 SHALL have `r_wdata` (input, 3): cell value to write; ld and gl only.
REQ-006 SHALL have `r_gnt` (output, 1): one-cycle pulse, access issued this cycle.
REQ-007 SHALL have `r_rvalid` (output, 1): read data valid, one cycle after the read grant.
REQ-008 SHALL have `r_rdata` (output, 3): read data, meaningful only while r_rvalid is high.
REQ-009 SHALL have `mem_x` (output, 6) and `mem_y` (output, 5): grid memory port address.
REQ-010 SHALL have `mem_we` (output, 1), `mem_wdata` (output, 3) and `mem_rdata` (input, 3): grid memory data; memory read latency is 1 cycle.
REQ-011 SHALL have `ld_lock` (input, 1): while high, the loader owns the port exclusively.
REQ-012 SHALL have `range_err` (output, 1): sticky flag for an out-of-range access.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE and LOCKED.
REQ-014 In IDLE, any req SHALL move the FSM to ISSUE, or ld_lock & ld_req SHALL move it to LOCKED.
REQ-015 In ISSUE, the FSM SHALL return to IDLE unless another req is pending.
REQ-016 In LOCKED, the FSM SHALL return to IDLE when ld_lock falls.
REQ-017 Arbitration SHALL be evaluated every cycle, at most one grant per cycle.
REQ-018 Arbitration SHALL give ld absolute priority; gl and rd SHALL alternate round-robin.
REQ-019 The round-robin pointer SHALL flip only when gl or rd is granted.
REQ-020 On a grant, mem_x, mem_y, mem_we and mem_wdata SHALL be driven combinationally from the granted requester in the same cycle as r_gnt.
REQ-021 mem_we SHALL be 0 when no grant is issued.
REQ-022 A read grant SHALL set r_rvalid exactly one cycle later, with r_rdata = mem_rdata registered; other requesters' rvalid SHALL stay 0.
REQ-023 While in LOCKED, gl and rd SHALL receive no grants; their req stays pending; ld SHALL be granted every cycle ld_req is high, for full-rate grid fill.
REQ-024 An access with x > 39 or y > 29 SHALL still be granted, with mem_we forced to 0.
REQ-025 For such an out-of-range access, a read SHALL return rdata = 0 with rvalid, and range_err SHALL set and remain set until reset.
REQ-026 If ld_lock rises while a gl/rd read's rvalid is outstanding, that rvalid SHALL still complete in the next cycle.
REQ-027 Simultaneous gl and rd requests with the pointer at gl SHALL grant gl first and rd on the next free cycle.
REQ-028 A requester that drops req before its grant SHALL simply lose the request, with no error.

Reset
REQ-029 On reset, state SHALL go to IDLE, the round-robin pointer to gl, and range_err to 0.
REQ-030 On reset, all gnt, rvalid and mem_we outputs SHALL go to 0, and rdata, mem_x, mem_y and mem_wdata to 0.
REQ-031 Reset mid-access SHALL cancel any pending rvalid.
REQ-032 Requests present during reset SHALL be re-arbitrated from the first cycle after reset.

Structure
REQ-033 A shared package SHALL hold GRID_W = 40, GRID_H = 30, the cell width of 3, the coordinate widths 6/5, and the FSM state encoding.
REQ-034 One sub-module, grid_rr_pick, SHALL contain the 2-way round-robin selector and its pointer register.
REQ-035 The arbiter SHALL contain no grid storage.

Verification
REQ-036 Reset held 2 cycles with all req high SHALL keep all outputs 0; first post-reset cycle: ld_gnt = 1.
REQ-037 gl and rd reading (3,4) and (5,6) together, memory model returning x+y SHALL give gl_gnt at t, gl_rvalid at t+1 with 7, rd_gnt at t+1, rd_rvalid at t+2 with 11 (truncated to 3 bits: 3).
REQ-038 ld_lock high while ld writes all 1200 cells SHALL produce 1200 consecutive ld_gnt, zero gl/rd grants, and a pending gl grant the cycle after ld_lock falls.
REQ-039 A gl write to (40,0) SHALL give gl_gnt = 1, mem_we = 0 and range_err = 1; a later gl read of (39,29) SHALL succeed with range_err still 1.
REQ-040 Reset asserted the cycle after an rd read grant SHALL leave rd_rvalid at 0.
REQ-041 Continuous gl and rd reads for 100 cycles SHALL give each exactly 50 grants, alternating.

Source files
------------

// File: rtl/grid_arbiter_pkg.sv
// Shared constants and types for the grid memory arbiter.
// Holds the grid geometry, field widths and the arbiter FSM encoding.
package grid_arbiter_pkg;

   localparam int GRID_W = 40;
   localparam int GRID_H = 30;
   localparam int CELL_W = 3;
   localparam int X_W    = 6;
   localparam int Y_W    = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   // Coordinates beyond the visible grid still fit the address fields.
   function automatic logic out_of_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x > X_W'(GRID_W - 1)) || (y > Y_W'(GRID_H - 1));
   endfunction

endpackage

// File: rtl/grid_rr_pick.sv
// Two-way round-robin selector between game logic (a) and renderer (b).
// The pointer moves past whichever side wins, so a held pair alternates.
module grid_rr_pick (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic ptr_b;

   always_comb begin
      gnt_a = enable & req_a & (~ptr_b | ~req_b);
      gnt_b = enable & req_b & (ptr_b | ~req_a);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_b <= 1'b0;
      end else if (gnt_a | gnt_b) begin
         ptr_b <= gnt_a;
      end
   end

endmodule

// File: rtl/grid_arbiter.sv
// Single-port grid memory arbiter for loader, game logic and renderer.
// Loader has absolute priority and can lock the port for a full-rate fill.
module grid_arbiter
   import grid_arbiter_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [X_W-1:0]    ld_x,
   input  logic [Y_W-1:0]    ld_y,
   input  logic [CELL_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [CELL_W-1:0] ld_rdata,
   input  logic              gl_req,
   input  logic              gl_we,
   input  logic [X_W-1:0]    gl_x,
   input  logic [Y_W-1:0]    gl_y,
   input  logic [CELL_W-1:0] gl_wdata,
   output logic              gl_gnt,
   output logic              gl_rvalid,
   output logic [CELL_W-1:0] gl_rdata,
   input  logic              rd_req,
   input  logic              rd_we,
   input  logic [X_W-1:0]    rd_x,
   input  logic [Y_W-1:0]    rd_y,
   output logic              rd_gnt,
   output logic              rd_rvalid,
   output logic [CELL_W-1:0] rd_rdata,
   output logic [X_W-1:0]    mem_x,
   output logic [Y_W-1:0]    mem_y,
   output logic              mem_we,
   output logic [CELL_W-1:0] mem_wdata,
   input  logic [CELL_W-1:0] mem_rdata,
   input  logic              ld_lock,
   output logic              range_err
);

   arb_state_t        state, state_next;
   logic              any_req, exclusive, rr_en;
   logic              gl_pick, rd_pick, any_gnt;
   logic [X_W-1:0]    sel_x;
   logic [Y_W-1:0]    sel_y;
   logic              sel_we, sel_oor;
   logic [CELL_W-1:0] sel_wdata, read_data;
   logic [2:0]        rvalid_q;
   logic              oor_q, err_q;
   logic              unused_rd_we;

   // The renderer is read-only; its write-enable pin is accepted but never acted on.
   assign unused_rd_we = rd_we;

   assign any_req   = ld_req | gl_req | rd_req;
   assign exclusive = ld_lock | (state == LOCKED);
   assign rr_en     = ~reset & ~ld_req & ~exclusive;

   grid_rr_pick u_rr_pick (
      .clock  (clock),
      .reset  (reset),
      .enable (rr_en),
      .req_a  (gl_req),
      .req_b  (rd_req),
      .gnt_a  (gl_pick),
      .gnt_b  (rd_pick)
   );

   // Route the winner onto the memory port in the same cycle as its grant.
   always_comb begin
      ld_gnt    = ~reset & ld_req;
      gl_gnt    = gl_pick;
      rd_gnt    = rd_pick;
      sel_x     = '0;
      sel_y     = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      if (ld_gnt) begin
         sel_x     = ld_x;
         sel_y     = ld_y;
         sel_we    = ld_we;
         sel_wdata = ld_wdata;
      end else if (gl_pick) begin
         sel_x     = gl_x;
         sel_y     = gl_y;
         sel_we    = gl_we;
         sel_wdata = gl_wdata;
      end else if (rd_pick) begin
         sel_x = rd_x;
         sel_y = rd_y;
      end
      any_gnt   = ld_gnt | gl_pick | rd_pick;
      sel_oor   = any_gnt & out_of_range(sel_x, sel_y);
      mem_x     = sel_x;
      mem_y     = sel_y;
      mem_we    = sel_we & ~sel_oor;
      mem_wdata = sel_wdata;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, ISSUE: begin
            if (ld_lock & ld_req) state_next = LOCKED;
            else if (any_req)     state_next = ISSUE;
            else                  state_next = IDLE;
         end
         LOCKED: begin
            if (!ld_lock) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         rvalid_q <= '0;
         oor_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_next;
         rvalid_q <= {rd_pick, gl_pick & ~gl_we, ld_gnt & ~ld_we};
         oor_q    <= sel_oor;
         err_q    <= err_q | sel_oor;
      end
   end

   // Read data follows the memory's one-cycle latency; out-of-range reads return zero.
   always_comb begin
      read_data = oor_q ? '0 : mem_rdata;
      ld_rvalid = ~reset & rvalid_q[0];
      gl_rvalid = ~reset & rvalid_q[1];
      rd_rvalid = ~reset & rvalid_q[2];
      ld_rdata  = ld_rvalid ? read_data : '0;
      gl_rdata  = gl_rvalid ? read_data : '0;
      rd_rdata  = rd_rvalid ? read_data : '0;
      range_err = ~reset & (err_q | sel_oor);
   end

endmodule

// File: tb/tb_grid_arbiter.sv
// Scoreboard bench for grid_arbiter with an x+y grid memory model.
// Expected outputs are queued as each cycle's stimulus is applied.
module tb_grid_arbiter;
   import grid_arbiter_pkg::*;

   logic       clock, reset;
   logic       ld_req, ld_we, ld_gnt, ld_rvalid;
   logic [5:0] ld_x;
   logic [4:0] ld_y;
   logic [2:0] ld_wdata, ld_rdata;
   logic       gl_req, gl_we, gl_gnt, gl_rvalid;
   logic [5:0] gl_x;
   logic [4:0] gl_y;
   logic [2:0] gl_wdata, gl_rdata;
   logic       rd_req, rd_we, rd_gnt, rd_rvalid;
   logic [5:0] rd_x;
   logic [4:0] rd_y;
   logic [2:0] rd_rdata;
   logic [5:0] mem_x;
   logic [4:0] mem_y;
   logic       mem_we, ld_lock, range_err;
   logic [2:0] mem_wdata, mem_rdata;

   typedef struct packed {
      logic [2:0] gnt;
      logic [2:0] rvalid;
      logic [8:0] rdata;
      logic [5:0] mx;
      logic [4:0] my;
      logic       mwe;
      logic [2:0] mwd;
      logic       err;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         ld_cnt = 0, gl_cnt = 0, rd_cnt = 0;
   int         base_ld, base_gl, base_rd;
   logic       one_shot;
   logic       last_gl_gnt;
   logic       m_locked, m_ptr_rd, m_err, m_oor;
   logic [2:0] m_rv, m_sum;

   grid_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .ld_req    (ld_req),
      .ld_we     (ld_we),
      .ld_x      (ld_x),
      .ld_y      (ld_y),
      .ld_wdata  (ld_wdata),
      .ld_gnt    (ld_gnt),
      .ld_rvalid (ld_rvalid),
      .ld_rdata  (ld_rdata),
      .gl_req    (gl_req),
      .gl_we     (gl_we),
      .gl_x      (gl_x),
      .gl_y      (gl_y),
      .gl_wdata  (gl_wdata),
      .gl_gnt    (gl_gnt),
      .gl_rvalid (gl_rvalid),
      .gl_rdata  (gl_rdata),
      .rd_req    (rd_req),
      .rd_we     (rd_we),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_gnt    (rd_gnt),
      .rd_rvalid (rd_rvalid),
      .rd_rdata  (rd_rdata),
      .mem_x     (mem_x),
      .mem_y     (mem_y),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .ld_lock   (ld_lock),
      .range_err (range_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Grid memory stand-in: every cell reads back as x+y, one cycle after the address.
   always @(posedge clock) mem_rdata <= 3'(mem_x + mem_y);

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic compareCycle();
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("ld_gnt",    ld_gnt,    e.gnt[0]);
      checkOutput("gl_gnt",    gl_gnt,    e.gnt[1]);
      checkOutput("rd_gnt",    rd_gnt,    e.gnt[2]);
      checkOutput("ld_rvalid", ld_rvalid, e.rvalid[0]);
      checkOutput("gl_rvalid", gl_rvalid, e.rvalid[1]);
      checkOutput("rd_rvalid", rd_rvalid, e.rvalid[2]);
      checkOutput("ld_rdata",  ld_rdata,  e.rdata[2:0]);
      checkOutput("gl_rdata",  gl_rdata,  e.rdata[5:3]);
      checkOutput("rd_rdata",  rd_rdata,  e.rdata[8:6]);
      checkOutput("mem_x",     mem_x,     e.mx);
      checkOutput("mem_y",     mem_y,     e.my);
      checkOutput("mem_we",    mem_we,    e.mwe);
      checkOutput("mem_wdata", mem_wdata, e.mwd);
      checkOutput("range_err", range_err, e.err);
      ld_cnt += int'(ld_gnt);
      gl_cnt += int'(gl_gnt);
      rd_cnt += int'(rd_gnt);
      last_gl_gnt = gl_gnt;
   endtask

   // One clock cycle: predict, queue, compare mid-cycle, then advance the model.
   task automatic applyStimulus();
      exp_t e;
      logic excl, ggl, grd, oor;
      e   = '0;
      ggl = 1'b0;
      grd = 1'b0;
      oor = 1'b0;
      if (!reset) begin
         excl     = ld_lock | m_locked;
         ggl      = !ld_req && !excl && gl_req && (!m_ptr_rd || !rd_req);
         grd      = !ld_req && !excl && rd_req && (m_ptr_rd || !gl_req);
         e.gnt    = {grd, ggl, ld_req};
         if (ld_req) begin
            e.mx = ld_x; e.my = ld_y; e.mwe = ld_we; e.mwd = ld_wdata;
         end else if (ggl) begin
            e.mx = gl_x; e.my = gl_y; e.mwe = gl_we; e.mwd = gl_wdata;
         end else if (grd) begin
            e.mx = rd_x; e.my = rd_y;
         end
         oor = (e.gnt != 3'b000) && (e.mx >= 6'd40 || e.my >= 5'd30);
         if (oor) e.mwe = 1'b0;
         e.rvalid = m_rv;
         for (int r = 0; r < 3; r++)
            e.rdata[3*r +: 3] = (m_rv[r] && !m_oor) ? m_sum : 3'd0;
         e.err = m_err | oor;
      end
      sb_q.push_back(e);
      #1;
      compareCycle();
      @(posedge clock);
      if (reset) begin
         m_locked = 1'b0; m_ptr_rd = 1'b0; m_err = 1'b0;
         m_rv = 3'b000; m_oor = 1'b0; m_sum = 3'd0;
      end else begin
         m_locked = m_locked ? ld_lock : (ld_lock & ld_req);
         if (ggl) m_ptr_rd = 1'b1;
         else if (grd) m_ptr_rd = 1'b0;
         m_err = e.err;
         m_rv  = {grd, ggl & !gl_we, e.gnt[0] & !ld_we};
         m_oor = oor;
         m_sum = 3'(e.mx + e.my);
      end
      @(negedge clock);
      if (one_shot) begin
         if (e.gnt[0]) ld_req = 1'b0;
         if (ggl)      gl_req = 1'b0;
         if (grd)      rd_req = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; ld_lock = 1'b0; one_shot = 1'b1;
      ld_req = 0; ld_we = 0; ld_x = 0; ld_y = 0; ld_wdata = 0;
      gl_req = 0; gl_we = 0; gl_x = 0; gl_y = 0; gl_wdata = 0;
      rd_req = 0; rd_we = 0; rd_x = 0; rd_y = 0;
      m_locked = 0; m_ptr_rd = 0; m_err = 0; m_rv = 0; m_oor = 0; m_sum = 0;
      @(negedge clock);

      // Reset held with every requester asking, then ld wins the first free cycle.
      ld_req = 1; ld_we = 1; ld_x = 1; ld_y = 1; ld_wdata = 2;
      gl_req = 1; gl_we = 0; gl_x = 2; gl_y = 3;
      rd_req = 1; rd_we = 1; rd_x = 4; rd_y = 5;
      repeat (2) applyStimulus();
      reset = 0;
      repeat (4) applyStimulus();

      // Simultaneous gl/rd reads: gl first, rd next, data 7 then 3.
      gl_req = 1; gl_x = 3; gl_y = 4;
      rd_req = 1; rd_x = 5; rd_y = 6;
      repeat (4) applyStimulus();

      // gl asks while ld owns the cycle, then withdraws.
      ld_req = 1; ld_we = 1; ld_x = 10; ld_y = 10; ld_wdata = 6;
      gl_req = 1; gl_x = 9; gl_y = 9;
      applyStimulus();
      gl_req = 0;
      applyStimulus();

      // gl read outstanding as the lock rises, then a full 1200-cell fill.
      gl_req = 1; gl_we = 0; gl_x = 1; gl_y = 2;
      applyStimulus();
      one_shot = 0;
      ld_lock = 1; ld_req = 1; ld_we = 1;
      gl_req = 1; gl_x = 20; gl_y = 20;
      base_ld = ld_cnt; base_gl = gl_cnt; base_rd = rd_cnt;
      for (int y = 0; y < GRID_H; y++) begin
         for (int x = 0; x < GRID_W; x++) begin
            ld_x = 6'(x); ld_y = 5'(y); ld_wdata = 3'(x + y);
            applyStimulus();
         end
      end
      checkOutput("fill_ld_grants", ld_cnt - base_ld, 1200);
      checkOutput("fill_glrd_grants", (gl_cnt - base_gl) + (rd_cnt - base_rd), 0);
      ld_lock = 0; ld_req = 0;
      applyStimulus();
      checkOutput("gl_held_at_unlock", last_gl_gnt, 0);
      one_shot = 1;
      applyStimulus();
      checkOutput("gl_after_unlock", last_gl_gnt, 1);
      applyStimulus();

      // Out-of-range write, in-range corner read, out-of-range read.
      gl_req = 1; gl_we = 1; gl_x = 40; gl_y = 0; gl_wdata = 5;
      repeat (2) applyStimulus();
      gl_req = 1; gl_we = 0; gl_x = 39; gl_y = 29;
      repeat (2) applyStimulus();
      rd_req = 1; rd_x = 10; rd_y = 30;
      repeat (2) applyStimulus();

      // Reset right after an rd read grant cancels its rvalid.
      rd_req = 1; rd_x = 2; rd_y = 2;
      applyStimulus();
      reset = 1;
      applyStimulus();
      reset = 0;
      applyStimulus();

      // Continuous gl and rd reads share the port evenly.
      one_shot = 0;
      gl_req = 1; gl_we = 0; gl_x = 7; gl_y = 7;
      rd_req = 1; rd_x = 8; rd_y = 1;
      base_gl = gl_cnt; base_rd = rd_cnt;
      repeat (100) applyStimulus();
      checkOutput("rr_gl_grants", gl_cnt - base_gl, 50);
      checkOutput("rr_rd_grants", rd_cnt - base_rd, 50);
      gl_req = 0; rd_req = 0;
      repeat (2) applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
